control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 89 ++++++++
 rtl/control_unit_if.sv | 37 +++
 rtl/imm_gen.sv | 29 ++
 rtl/control_unit.sv | 160 ++++++++++++++++
 tb/tb_control_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the RV64I load/store/ALU control unit.
// Opcodes, ALU codes, mux selects, FSM states and the decoded control bundle.
package cpu_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   localparam logic [2:0] F3_D      = 3'b011;
   localparam logic [2:0] F3_ADD    = 3'b000;

   localparam logic [6:0] F7_ADD    = 7'b0000000;
   localparam logic [6:0] F7_SUB    = 7'b0100000;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;

   localparam logic MUX0_RF_A = 1'b0;
   localparam logic MUX0_RF_B = 1'b1;
   localparam logic MUX1_IMM  = 1'b0;
   localparam logic MUX1_RF_B = 1'b1;
   localparam logic MUX2_ALU  = 1'b0;
   localparam logic MUX2_DMEM = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      OP_BAD,
      OP_LD,
      OP_SD,
      OP_ADD,
      OP_SUB
   } op_t;

   typedef enum logic [1:0] {
      IMM_ZERO,
      IMM_I,
      IMM_S
   } imm_fmt_t;

   typedef struct packed {
      logic [4:0] addr_a;
      logic [4:0] addr_b;
      logic [4:0] wr_addr;
      logic       mux_0;
      logic       mux_1;
      logic       mux_2;
      logic [2:0] alu;
   } ctrl_t;

   function automatic op_t classify(input logic [31:0] ir);
      op_t  op;
      logic is_ld;
      logic is_sd;
      logic is_add;
      logic is_sub;
      is_ld  = (ir[6:0] == OPC_LOAD) && (ir[14:12] == F3_D);
      is_sd  = (ir[6:0] == OPC_STORE) && (ir[14:12] == F3_D);
      is_add = (ir[6:0] == OPC_OP) && (ir[14:12] == F3_ADD)
               && (ir[31:25] == F7_ADD);
      is_sub = (ir[6:0] == OPC_OP) && (ir[14:12] == F3_ADD)
               && (ir[31:25] == F7_SUB);
      op = OP_BAD;
      unique case (1'b1)
         is_ld:   op = OP_LD;
         is_sd:   op = OP_SD;
         is_add:  op = OP_ADD;
         is_sub:  op = OP_SUB;
         default: op = OP_BAD;
      endcase
      return op;
   endfunction

   function automatic imm_fmt_t fmt_of(input op_t op);
      imm_fmt_t f;
      f = IMM_ZERO;
      if (op == OP_LD) f = IMM_I;
      if (op == OP_SD) f = IMM_S;
      return f;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction handshake and datapath control bundle of the control unit.
// slave is the control unit, master is the fetch/datapath side.
interface control_unit_if #(
   parameter int WORDSIZE = 64
);
   logic [31:0]         cu_instr;
   logic                cu_instr_valid;
   logic                cu_instr_ready;
   logic [4:0]          cu_rf_addr_a;
   logic [4:0]          cu_rf_addr_b;
   logic [4:0]          cu_rf_write_addr;
   logic                cu_rf_write_en;
   logic [WORDSIZE-1:0] cu_immediate;
   logic                cu_mux_0_sel;
   logic                cu_mux_1_sel;
   logic                cu_mux_2_sel;
   logic [2:0]          cu_alu_operation;
   logic                cu_dm_write_en;
   logic                cu_done;
   logic                cu_illegal;

   modport master (
      output cu_instr, cu_instr_valid,
      input  cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b,
      input  cu_rf_write_addr, cu_rf_write_en, cu_immediate,
      input  cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel,
      input  cu_alu_operation, cu_dm_write_en, cu_done, cu_illegal
   );

   modport slave (
      input  cu_instr, cu_instr_valid,
      output cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b,
      output cu_rf_write_addr, cu_rf_write_en, cu_immediate,
      output cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel,
      output cu_alu_operation, cu_dm_write_en, cu_done, cu_illegal
   );
endinterface

// File: rtl/imm_gen.sv
// Immediate former: picks the I or S field and sign-extends bit 11.
// Purely combinational; the zero format is used for register-register ops.
module imm_gen
   import cpu_pkg::*;
#(
   parameter int WORDSIZE = 64
) (
   input  logic [31:0]         ir,
   input  imm_fmt_t            fmt,
   output logic [WORDSIZE-1:0] imm
);

   logic [11:0] raw;
   logic        unused_ir;

   assign unused_ir = ^{ir[19:12], ir[6:0]};

   // select the 12-bit field, then replicate its sign bit upward
   always_comb begin
      raw = '0;
      unique case (fmt)
         IMM_I:   raw = ir[31:20];
         IMM_S:   raw = {ir[31:25], ir[11:7]};
         default: raw = '0;
      endcase
      imm = {{(WORDSIZE-12){raw[11]}}, raw};
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit for RV64I ld, sd, add and sub.
// Control outputs are registered at accept and held for the whole instruction.
module control_unit
   import cpu_pkg::*;
#(
   parameter int WORDSIZE = 64
) (
   input logic           cu_clk,
   input logic           cu_rst_n,
   control_unit_if.slave bus
);

   state_t              state_q;
   state_t              state_d;
   logic [31:0]         ir_q;
   op_t                 op_q;
   op_t                 op_in;
   op_t                 op_ir;
   imm_fmt_t            fmt_in;
   ctrl_t               ctrl_q;
   ctrl_t               ctrl_in;
   logic [WORDSIZE-1:0] imm_q;
   logic [WORDSIZE-1:0] imm_in;
   logic                accept;
   logic                ready_c;
   logic                rf_we_c;
   logic                dm_we_c;
   logic                done_c;
   logic                illegal_c;
   logic                unused_ir;

   assign op_in     = classify(bus.cu_instr);
   assign op_ir     = classify(ir_q);
   assign fmt_in    = fmt_of(op_in);
   assign accept    = (state_q == S_IDLE) && bus.cu_instr_valid;
   assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

   imm_gen #(
      .WORDSIZE(WORDSIZE)
   ) u_imm_gen (
      .ir  (bus.cu_instr),
      .fmt (fmt_in),
      .imm (imm_in)
   );

   // map the incoming word onto register addresses, selects and ALU op
   always_comb begin
      ctrl_in = '0;
      unique case (op_in)
         OP_LD: begin
            ctrl_in.addr_a  = bus.cu_instr[19:15];
            ctrl_in.addr_b  = bus.cu_instr[19:15];
            ctrl_in.wr_addr = bus.cu_instr[11:7];
            ctrl_in.mux_0   = MUX0_RF_A;
            ctrl_in.mux_1   = MUX1_IMM;
            ctrl_in.mux_2   = MUX2_DMEM;
            ctrl_in.alu     = ALU_ADD;
         end
         OP_SD: begin
            ctrl_in.addr_a  = bus.cu_instr[24:20];
            ctrl_in.addr_b  = bus.cu_instr[19:15];
            ctrl_in.mux_0   = MUX0_RF_B;
            ctrl_in.mux_1   = MUX1_IMM;
            ctrl_in.mux_2   = MUX2_ALU;
            ctrl_in.alu     = ALU_ADD;
         end
         OP_ADD, OP_SUB: begin
            ctrl_in.addr_a  = bus.cu_instr[19:15];
            ctrl_in.addr_b  = bus.cu_instr[24:20];
            ctrl_in.wr_addr = bus.cu_instr[11:7];
            ctrl_in.mux_0   = MUX0_RF_A;
            ctrl_in.mux_1   = MUX1_RF_B;
            ctrl_in.mux_2   = MUX2_ALU;
            ctrl_in.alu     = (op_in == OP_SUB) ? ALU_SUB : ALU_ADD;
         end
         default: ctrl_in = '0;
      endcase
   end

   // capture the control bundle on accept so it is stable from DECODE on
   always_ff @(posedge cu_clk) begin
      if (!cu_rst_n) begin
         ctrl_q <= '0;
         imm_q  <= '0;
      end else if (accept) begin
         ctrl_q <= ctrl_in;
         imm_q  <= imm_in;
      end
   end

   // state register, instruction register and the class found in DECODE
   always_ff @(posedge cu_clk) begin
      if (!cu_rst_n) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         op_q    <= OP_BAD;
      end else begin
         state_q <= state_d;
         if (accept) ir_q <= bus.cu_instr;
         if (state_q == S_DECODE) op_q <= op_ir;
      end
   end

   // next state and per-state strobes; enables only in MEM or WB
   always_comb begin
      state_d   = state_q;
      ready_c   = 1'b0;
      rf_we_c   = 1'b0;
      dm_we_c   = 1'b0;
      done_c    = 1'b0;
      illegal_c = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
            if (bus.cu_instr_valid) state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = (op_ir == OP_BAD) ? S_TRAP : S_EXEC;
         end
         S_EXEC: begin
            if (op_q == OP_LD || op_q == OP_SD) state_d = S_MEM;
            else state_d = S_WB;
         end
         S_MEM: begin
            if (op_q == OP_SD) begin
               dm_we_c = 1'b1;
               done_c  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            rf_we_c = (ctrl_q.wr_addr != 5'd0);
            done_c  = 1'b1;
            state_d = S_IDLE;
         end
         S_TRAP: begin
            illegal_c = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cu_instr_ready   = ready_c;
   assign bus.cu_rf_write_en   = rf_we_c;
   assign bus.cu_dm_write_en   = dm_we_c;
   assign bus.cu_done          = done_c;
   assign bus.cu_illegal       = illegal_c;
   assign bus.cu_rf_addr_a     = ctrl_q.addr_a;
   assign bus.cu_rf_addr_b     = ctrl_q.addr_b;
   assign bus.cu_rf_write_addr = ctrl_q.wr_addr;
   assign bus.cu_mux_0_sel     = ctrl_q.mux_0;
   assign bus.cu_mux_1_sel     = ctrl_q.mux_1;
   assign bus.cu_mux_2_sel     = ctrl_q.mux_2;
   assign bus.cu_alu_operation = ctrl_q.alu;
   assign bus.cu_immediate     = imm_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: ld, sd, add/sub, traps, x0, reset abort.
// Cycle n after accept edge k is sampled on the negedge before edge k+n.
module tb_control_unit;

   logic cu_clk = 1'b0;
   logic cu_rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   control_unit_if #(.WORDSIZE(64)) bus ();

   control_unit #(
      .WORDSIZE(64)
   ) dut (
      .cu_clk   (cu_clk),
      .cu_rst_n (cu_rst_n),
      .bus      (bus)
   );

   always #5 cu_clk = ~cu_clk;

   // {ready, rf_we, dm_we, done, illegal}
   wire [4:0] flags = {bus.cu_instr_ready, bus.cu_rf_write_en,
                       bus.cu_dm_write_en, bus.cu_done, bus.cu_illegal};
   // {addr_a, addr_b, write_addr, mux0, mux1, mux2, alu}
   wire [20:0] ctrl_obs = {bus.cu_rf_addr_a, bus.cu_rf_addr_b,
                           bus.cu_rf_write_addr, bus.cu_mux_0_sel,
                           bus.cu_mux_1_sel, bus.cu_mux_2_sel,
                           bus.cu_alu_operation};

   // present one word for one cycle; returns at the negedge of cycle k+1
   task automatic issue(input logic [31:0] w);
      bus.cu_instr       = w;
      bus.cu_instr_valid = 1'b1;
      @(negedge cu_clk);
      bus.cu_instr_valid = 1'b0;
      bus.cu_instr       = 32'h0;
   endtask

   task automatic test_reset();
      cu_rst_n = 1'b0;
      repeat (2) @(negedge cu_clk);
      vectors++;
      if (flags !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_flags got %b want %b", flags, 5'b10000);
      end
      vectors++;
      if (ctrl_obs !== 21'h0) begin
         miscompares++;
         $display("FAIL reset_ctrl got %h want %h", ctrl_obs, 21'h0);
      end
      vectors++;
      if (bus.cu_immediate !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_imm got %h want 0", bus.cu_immediate);
      end
      cu_rst_n = 1'b1;
      @(negedge cu_clk);
      vectors++;
      if (flags !== 5'b10000) begin
         miscompares++;
         $display("FAIL idle_flags got %b want %b", flags, 5'b10000);
      end
   endtask

   // ld x2,5(x7)
   task automatic test_ld();
      logic [4:0]  fexp;
      logic [20:0] cexp;
      cexp = {5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b1, 3'b000};
      issue(32'h0053B103);
      vectors++;
      if (bus.cu_immediate !== 64'h5) begin
         miscompares++;
         $display("FAIL ld_imm got %h want %h", bus.cu_immediate, 64'h5);
      end
      for (int n = 1; n <= 5; n++) begin
         if (n > 1) @(negedge cu_clk);
         fexp = (n == 4) ? 5'b01010 : (n == 5) ? 5'b10000 : 5'b00000;
         vectors++;
         if (flags !== fexp) begin
            miscompares++;
            $display("FAIL ld_flags n=%0d got %b want %b", n, flags, fexp);
         end
         if (n <= 4) begin
            vectors++;
            if (ctrl_obs !== cexp) begin
               miscompares++;
               $display("FAIL ld_ctrl n=%0d got %h want %h",
                        n, ctrl_obs, cexp);
            end
         end
      end
   endtask

   // sd x4,23(x8)
   task automatic test_sd();
      logic [4:0]  fexp;
      logic [20:0] cexp;
      cexp = {5'd4, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000};
      issue(32'h00443BA3);
      vectors++;
      if (bus.cu_immediate !== 64'h17) begin
         miscompares++;
         $display("FAIL sd_imm got %h want %h", bus.cu_immediate, 64'h17);
      end
      for (int n = 1; n <= 4; n++) begin
         if (n > 1) @(negedge cu_clk);
         fexp = (n == 3) ? 5'b00110 : (n == 4) ? 5'b10000 : 5'b00000;
         vectors++;
         if (flags !== fexp) begin
            miscompares++;
            $display("FAIL sd_flags n=%0d got %b want %b", n, flags, fexp);
         end
         if (n <= 3) begin
            vectors++;
            if (ctrl_obs !== cexp) begin
               miscompares++;
               $display("FAIL sd_ctrl n=%0d got %h want %h",
                        n, ctrl_obs, cexp);
            end
         end
      end
   endtask

   // add x1,x2,x0 then sub x1,x0,x2 accepted on the very next edge
   task automatic test_back_to_back();
      logic [31:0] words [2];
      logic [20:0] cexp [2];
      logic [4:0]  fexp;
      words[0] = 32'h000100B3;
      words[1] = 32'h402000B3;
      cexp[0]  = {5'd2, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 3'b000};
      cexp[1]  = {5'd0, 5'd2, 5'd1, 1'b0, 1'b1, 1'b0, 3'b001};
      for (int i = 0; i < 2; i++) begin
         issue(words[i]);
         vectors++;
         if (bus.cu_immediate !== 64'h0) begin
            miscompares++;
            $display("FAIL rr_imm i=%0d got %h want 0", i, bus.cu_immediate);
         end
         for (int n = 1; n <= 4; n++) begin
            if (n > 1) @(negedge cu_clk);
            fexp = (n == 3) ? 5'b01010 : (n == 4) ? 5'b10000 : 5'b00000;
            vectors++;
            if (flags !== fexp) begin
               miscompares++;
               $display("FAIL rr_flags i=%0d n=%0d got %b want %b",
                        i, n, flags, fexp);
            end
            if (n <= 3) begin
               vectors++;
               if (ctrl_obs !== cexp[i]) begin
                  miscompares++;
                  $display("FAIL rr_ctrl i=%0d n=%0d got %h want %h",
                           i, n, ctrl_obs, cexp[i]);
               end
            end
         end
      end
   endtask

   // all-zero word traps, then add x0,x2,x3 completes without a write
   task automatic test_illegal_x0();
      logic [4:0]  fexp;
      logic [20:0] cexp;
      issue(32'h00000000);
      for (int n = 1; n <= 3; n++) begin
         if (n > 1) @(negedge cu_clk);
         fexp = (n == 2) ? 5'b00001 : (n == 3) ? 5'b10000 : 5'b00000;
         vectors++;
         if (flags !== fexp) begin
            miscompares++;
            $display("FAIL trap_flags n=%0d got %b want %b", n, flags, fexp);
         end
      end
      cexp = {5'd2, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000};
      issue(32'h00310033);
      for (int n = 1; n <= 4; n++) begin
         if (n > 1) @(negedge cu_clk);
         fexp = (n == 3) ? 5'b00010 : (n == 4) ? 5'b10000 : 5'b00000;
         vectors++;
         if (flags !== fexp) begin
            miscompares++;
            $display("FAIL x0_flags n=%0d got %b want %b", n, flags, fexp);
         end
         if (n == 3) begin
            vectors++;
            if (ctrl_obs !== cexp) begin
               miscompares++;
               $display("FAIL x0_ctrl got %h want %h", ctrl_obs, cexp);
            end
         end
      end
   endtask

   // ld aborted by reset sampled at accept+2
   task automatic test_reset_abort();
      issue(32'h0053B103);
      vectors++;
      if (flags !== 5'b00000) begin
         miscompares++;
         $display("FAIL abort_n1 got %b want %b", flags, 5'b00000);
      end
      @(negedge cu_clk);
      vectors++;
      if (flags !== 5'b00000) begin
         miscompares++;
         $display("FAIL abort_n2 got %b want %b", flags, 5'b00000);
      end
      cu_rst_n = 1'b0;
      @(negedge cu_clk);
      cu_rst_n = 1'b1;
      vectors++;
      if (flags !== 5'b10000) begin
         miscompares++;
         $display("FAIL abort_idle got %b want %b", flags, 5'b10000);
      end
      vectors++;
      if ({ctrl_obs, bus.cu_immediate} !== 85'h0) begin
         miscompares++;
         $display("FAIL abort_outs got %h/%h want 0",
                  ctrl_obs, bus.cu_immediate);
      end
      for (int n = 4; n <= 6; n++) begin
         @(negedge cu_clk);
         vectors++;
         if (flags !== 5'b10000) begin
            miscompares++;
            $display("FAIL abort_after n=%0d got %b want %b",
                     n, flags, 5'b10000);
         end
      end
   endtask

   // ld x3,-1(x1): full sign extension, accepted normally after abort
   task automatic test_neg_imm();
      logic [4:0]  fexp;
      logic [20:0] cexp;
      cexp = {5'd1, 5'd1, 5'd3, 1'b0, 1'b0, 1'b1, 3'b000};
      issue(32'hFFF0B183);
      vectors++;
      if (bus.cu_immediate !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         miscompares++;
         $display("FAIL neg_imm got %h want %h",
                  bus.cu_immediate, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      vectors++;
      if (ctrl_obs !== cexp) begin
         miscompares++;
         $display("FAIL neg_ctrl got %h want %h", ctrl_obs, cexp);
      end
      for (int n = 2; n <= 5; n++) begin
         @(negedge cu_clk);
         fexp = (n == 4) ? 5'b01010 : (n == 5) ? 5'b10000 : 5'b00000;
         vectors++;
         if (flags !== fexp) begin
            miscompares++;
            $display("FAIL neg_flags n=%0d got %b want %b", n, flags, fexp);
         end
      end
   endtask

   initial begin
      cu_rst_n           = 1'b0;
      bus.cu_instr       = 32'h0;
      bus.cu_instr_valid = 1'b0;
      test_reset();
      test_ld();
      test_sd();
      test_back_to_back();
      test_illegal_x0();
      test_reset_abort();
      test_neg_imm();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
